// File: rtl/ddr3_wb_arbiter.sv
// Two-master round-robin arbiter in front of the DDR3 controller's pipelined Wishbone port.
// Ownership lasts a whole cyc; outstanding requests per owner are capped at 2**LGMAXBURST.
module ddr3_wb_arbiter #(
  parameter int WB_ADDR_BITS = 24,
  parameter int WB_DATA_BITS = 128,
  parameter int WB_SEL_BITS  = WB_DATA_BITS/8,
  parameter int LGMAXBURST   = 5
) (
  input  logic                    i_controller_clk,
  input  logic                    i_rst,
  input  logic                    i_m0_cyc,
  input  logic                    i_m0_stb,
  input  logic                    i_m0_we,
  input  logic [WB_ADDR_BITS-1:0] i_m0_addr,
  input  logic [WB_DATA_BITS-1:0] i_m0_data,
  input  logic [WB_SEL_BITS-1:0]  i_m0_sel,
  output logic                    o_m0_stall,
  output logic                    o_m0_ack,
  output logic                    o_m0_err,
  output logic [WB_DATA_BITS-1:0] o_m0_data,
  input  logic                    i_m1_cyc,
  input  logic                    i_m1_stb,
  input  logic                    i_m1_we,
  input  logic [WB_ADDR_BITS-1:0] i_m1_addr,
  input  logic [WB_DATA_BITS-1:0] i_m1_data,
  input  logic [WB_SEL_BITS-1:0]  i_m1_sel,
  output logic                    o_m1_stall,
  output logic                    o_m1_ack,
  output logic                    o_m1_err,
  output logic [WB_DATA_BITS-1:0] o_m1_data,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [WB_ADDR_BITS-1:0] o_wb_addr,
  output logic [WB_DATA_BITS-1:0] o_wb_data,
  output logic [WB_SEL_BITS-1:0]  o_wb_sel,
  input  logic                    i_wb_stall,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic [WB_DATA_BITS-1:0] i_wb_data
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [LGMAXBURST:0] MAX_CNT = {1'b1, {LGMAXBURST{1'b0}}};
  localparam logic [LGMAXBURST:0] ONE     = {{LGMAXBURST{1'b0}}, 1'b1};

  state_t              state;
  logic                last;
  logic [LGMAXBURST:0] count;

  logic g0, g1, granted, own_cyc, own_stb, full, accept, resp;

  always_comb begin
    g0      = (state == GRANT0);
    g1      = (state == GRANT1);
    granted = g0 | g1;
    own_cyc = g1 ? i_m1_cyc : i_m0_cyc;
    own_stb = g1 ? i_m1_stb : i_m0_stb;
    full    = (count == MAX_CNT);

    // A dropped cyc also kills the strobe so an aborting master cannot sneak in one more request
    o_wb_cyc  = granted & own_cyc;
    o_wb_stb  = granted & own_cyc & own_stb & ~full;
    o_wb_we   = g1 ? i_m1_we   : i_m0_we;
    o_wb_addr = g1 ? i_m1_addr : i_m0_addr;
    o_wb_data = g1 ? i_m1_data : i_m0_data;
    o_wb_sel  = g1 ? i_m1_sel  : i_m0_sel;

    o_m0_stall = ~g0 | i_wb_stall | full;
    o_m1_stall = ~g1 | i_wb_stall | full;
    o_m0_ack   = g0 & i_wb_ack;
    o_m1_ack   = g1 & i_wb_ack;
    o_m0_err   = g0 & i_wb_err;
    o_m1_err   = g1 & i_wb_err;
    o_m0_data  = i_wb_data;
    o_m1_data  = i_wb_data;

    accept = o_wb_stb & ~i_wb_stall;
    resp   = i_wb_ack | i_wb_err;
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      state <= IDLE;
      count <= '0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (i_m0_cyc && (!i_m1_cyc || last)) begin
            state <= GRANT0;
            last  <= 1'b0;
          end else if (i_m1_cyc) begin
            state <= GRANT1;
            last  <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          // Release aborts whatever is still outstanding; the controller drops it with cyc
          if (!own_cyc) begin
            state <= IDLE;
            count <= '0;
          end else if (accept && !resp) begin
            count <= count + ONE;
          end else if (!accept && resp && count != '0) begin
            count <= count - ONE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
